window_stream_gen: RTL and testbench

//  Parametrised successor of the linebuffer/image_control pair. Takes a raster pixel stream
//  (valid/ready), stores KERNEL_W-1 previous lines in circular line buffers, and emits the full

---
 rtl/window_stream_gen.sv | 125 ++++++++++++
 tb/tb_window_stream_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_stream_gen.sv
// Raster pixel stream to KERNEL_W x KERNEL_W sliding-window stream with frame markers.
// Previous KERNEL_W-1 lines are held in circular line buffers indexed by the column counter.
module window_stream_gen #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned KERNEL_W = 3,
  parameter int unsigned IMG_W    = 512,
  parameter int unsigned IMG_H    = 512
) (
  input  logic                                  clk_i,
  input  logic                                  srst_i,
  input  logic [DATA_W-1:0]                     pix_i,
  input  logic                                  pix_sof_i,
  input  logic                                  pix_valid_i,
  output logic                                  pix_ready_o,
  output logic [KERNEL_W*KERNEL_W*DATA_W-1:0]   win_o,
  output logic                                  win_valid_o,
  input  logic                                  win_ready_i,
  output logic                                  win_sof_o,
  output logic                                  win_eol_o,
  output logic                                  win_eof_o,
  output logic                                  sof_err_o
);

  localparam int unsigned K     = KERNEL_W;
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);

  logic [COL_W-1:0]  col_q, col_eff, col_nxt;
  logic [ROW_W-1:0]  row_q, row_eff, row_nxt;
  logic              accept;
  logic              sof_bad;
  logic              win_hit;

  logic [DATA_W-1:0] lb      [K-1][IMG_W];
  logic [DATA_W-1:0] win_q   [K][K];
  logic [DATA_W-1:0] new_col [K];

  assign pix_ready_o = !win_valid_o || win_ready_i;
  assign accept      = pix_valid_i && pix_ready_o;
  assign sof_bad     = pix_sof_i && ((row_q != '0) || (col_q != '0));

  // An accepted sof always places its pixel at (0,0), abandoning any partial frame.
  always_comb begin
    col_eff = pix_sof_i ? '0 : col_q;
    row_eff = pix_sof_i ? '0 : row_q;
    win_hit = (row_eff >= ROW_FIRST) && (col_eff >= COL_FIRST);
    col_nxt = col_eff + COL_W'(1);
    row_nxt = row_eff;
    if (col_eff == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + ROW_W'(1);
    end
  end

  // Incoming column, oldest line at row 0, newest pixel at the bottom.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      new_col[r] = lb[K-2-r][col_eff];
    end
    new_col[K-1] = pix_i;
  end

  // Line buffer RAM is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb[0][col_eff] <= pix_i;
      for (int i = 1; i < K - 1; i++) begin
        lb[i][col_eff] <= lb[i-1][col_eff];
      end
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_o <= 1'b0;
      win_sof_o   <= 1'b0;
      win_eol_o   <= 1'b0;
      win_eof_o   <= 1'b0;
      sof_err_o   <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      sof_err_o <= accept && sof_bad;
      if (accept) begin
        col_q <= col_nxt;
        row_q <= row_nxt;
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
          win_q[r][K-1] <= new_col[r];
        end
        win_valid_o <= win_hit;
        win_sof_o   <= win_hit && (row_eff == ROW_FIRST) && (col_eff == COL_FIRST);
        win_eol_o   <= win_hit && (col_eff == COL_LAST);
        win_eof_o   <= win_hit && (row_eff == ROW_LAST) && (col_eff == COL_LAST);
      end else if (win_ready_i) begin
        win_valid_o <= 1'b0;
        win_sof_o   <= 1'b0;
        win_eol_o   <= 1'b0;
        win_eof_o   <= 1'b0;
      end
    end
  end

  always_comb begin
    win_o = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_o[(r*K+c)*DATA_W +: DATA_W] = win_q[r][c];
      end
    end
  end

endmodule

// File: tb/tb_window_stream_gen.sv
// Bench for window_stream_gen at K=3, 8x6 image, pixel = row*16+col.
module tb_window_stream_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned K  = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;
  localparam int unsigned WW = K * K * DW;
  localparam int unsigned NPIX = W * H;

  logic          clk_i = 1'b0;
  logic          srst_i;
  logic [DW-1:0] pix_i;
  logic          pix_sof_i;
  logic          pix_valid_i;
  logic          pix_ready_o;
  logic [WW-1:0] win_o;
  logic          win_valid_o;
  logic          win_ready_i;
  logic          win_sof_o;
  logic          win_eol_o;
  logic          win_eof_o;
  logic          sof_err_o;

  always #5 clk_i = ~clk_i;

  window_stream_gen #(.DATA_W(DW), .KERNEL_W(K), .IMG_W(W), .IMG_H(H)) dut (
    .clk_i(clk_i), .srst_i(srst_i),
    .pix_i(pix_i), .pix_sof_i(pix_sof_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .win_o(win_o), .win_valid_o(win_valid_o), .win_ready_i(win_ready_i),
    .win_sof_o(win_sof_o), .win_eol_o(win_eol_o), .win_eof_o(win_eof_o), .sof_err_o(sof_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    logic [WW-1:0] win;
    logic          sof;
    logic          eol;
    logic          eof;
  } exp_t;

  typedef struct {
    logic [DW-1:0] pix;
    logic          sof;
    logic          e_valid;
    logic          e_sof;
    logic          e_eol;
    logic          e_eof;
    logic [WW-1:0] e_win;
  } vec_t;

  exp_t sb[$];
  vec_t tv[NPIX];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pix_val(input int idx);
    return DW'((idx / W) * 16 + idx % W);
  endfunction

  function automatic logic [WW-1:0] exp_win(input int idx);
    logic [WW-1:0] w;
    int rr, cc;
    rr = idx / W;
    cc = idx % W;
    w = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w[(r*K+c)*DW +: DW] = DW'((rr - (K - 1) + r) * 16 + (cc - (K - 1) + c));
      end
    end
    return w;
  endfunction

  task automatic push_exp(input int first, input int n);
    exp_t e;
    int rr, cc;
    for (int i = first; i < first + n; i++) begin
      rr = i / W;
      cc = i % W;
      if (rr >= K - 1 && cc >= K - 1) begin
        e.win = exp_win(i);
        e.sof = (rr == K - 1) && (cc == K - 1);
        e.eol = (cc == W - 1);
        e.eof = (rr == H - 1) && (cc == W - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_pixel(input logic [DW-1:0] p, input logic sof, input bit gaps);
    if (gaps && $urandom_range(0, 2) == 0) begin
      pix_valid_i = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk_i);
      #1;
    end
    pix_i       = p;
    pix_sof_i   = sof;
    pix_valid_i = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_i);
      if (pix_ready_o) begin
        @(posedge clk_i);
        #1;
        pix_valid_i = 1'b0;
        pix_sof_i   = 1'b0;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL accept_timeout: pixel %0h not accepted within 200 cycles", p);
    pix_valid_i = 1'b0;
    pix_sof_i   = 1'b0;
  endtask

  task automatic send_pixels(input int first, input int n, input bit sof_first, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      send_pixel(pix_val(i), sof_first && (i == first), gaps);
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 2000 && sb.size() != 0; t++) @(posedge clk_i);
    chk("windows_outstanding", 128'(sb.size()), 128'd0);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: every output handshake must match the next expected window.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (mon_en && win_valid_o && win_ready_i) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_window: got %0h with no window expected", win_o);
      end else begin
        e = sb.pop_front();
        chk("win_data", win_o, e.win);
        chk("win_sof", win_sof_o, e.sof);
        chk("win_eol", win_eol_o, e.eol);
        chk("win_eof", win_eof_o, e.eof);
      end
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (rdy_mode == 0) win_ready_i = 1'b1;
    else if (rdy_mode == 1) win_ready_i = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] first_w;
    logic [WW-1:0] held;
    int rr, cc;

    first_w = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
    for (int i = 0; i < int'(NPIX); i++) begin
      rr = i / W;
      cc = i % W;
      tv[i].pix     = pix_val(i);
      tv[i].sof     = (i == 0);
      tv[i].e_valid = (rr >= K - 1) && (cc >= K - 1);
      tv[i].e_sof   = (rr == K - 1) && (cc == K - 1);
      tv[i].e_eol   = tv[i].e_valid && (cc == W - 1);
      tv[i].e_eof   = (rr == H - 1) && (cc == W - 1);
      tv[i].e_win   = exp_win(i);
    end

    pix_i = '0; pix_sof_i = 1'b0; pix_valid_i = 1'b0; win_ready_i = 1'b1;
    srst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2 srst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Reset state
    chk("rst_win_valid", win_valid_o, 0);
    chk("rst_win", win_o, 0);
    chk("rst_markers", {win_sof_o, win_eol_o, win_eof_o}, 0);
    chk("rst_sof_err", sof_err_o, 0);
    chk("rst_pix_ready", pix_ready_o, 1);

    // Full frame, cycle-exact, table driven
    for (int i = 0; i < int'(NPIX); i++) begin
      pix_i = tv[i].pix;
      pix_sof_i = tv[i].sof;
      pix_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("tbl_valid", win_valid_o, tv[i].e_valid);
      chk("tbl_sof", win_sof_o, tv[i].e_sof);
      chk("tbl_eol", win_eol_o, tv[i].e_eol);
      chk("tbl_eof", win_eof_o, tv[i].e_eof);
      chk("tbl_sof_err", sof_err_o, 0);
      if (tv[i].e_valid) chk("tbl_win", win_o, tv[i].e_win);
      if (i == 18) chk("first_window", win_o, first_w);
    end
    pix_valid_i = 1'b0;
    pix_sof_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("tbl_drain_valid", win_valid_o, 0);
    mon_en = 1'b1;

    // Downstream stall mid-line
    push_exp(0, NPIX);
    fork
      send_pixels(0, NPIX, 1'b1, 1'b0);
      begin
        repeat (22) @(posedge clk_i);
        #1;
        rdy_mode = 2;
        win_ready_i = 1'b0;
        held = win_o;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk_i);
          chk("stall_valid", win_valid_o, 1);
          chk("stall_pix_ready", pix_ready_o, 0);
          chk("stall_win_hold", win_o, held);
        end
        @(posedge clk_i);
        #1;
        rdy_mode = 0;
        win_ready_i = 1'b1;
      end
    join
    wait_drain();

    // Random input gaps and random downstream ready
    rdy_mode = 1;
    push_exp(0, NPIX);
    send_pixels(0, NPIX, 1'b1, 1'b1);
    wait_drain();
    rdy_mode = 0;

    // Unexpected sof at (3,4), then a full frame
    push_exp(0, 28);
    send_pixels(0, 28, 1'b1, 1'b0);
    push_exp(0, NPIX);
    send_pixel(pix_val(0), 1'b1, 1'b0);
    chk("sof_err_pulse", sof_err_o, 1);
    send_pixel(pix_val(1), 1'b0, 1'b0);
    chk("sof_err_clear", sof_err_o, 0);
    send_pixels(2, NPIX - 2, 1'b0, 1'b0);
    wait_drain();

    // Asynchronous reset mid-line
    push_exp(0, 20);
    send_pixels(0, 20, 1'b1, 1'b0);
    @(negedge clk_i);
    #2;
    chk("pre_reset_valid", win_valid_o, 1);
    srst_i = 1'b1;
    #1;
    chk("async_rst_valid", win_valid_o, 0);
    chk("async_rst_win", win_o, 0);
    chk("async_rst_markers", {win_sof_o, win_eol_o, win_eof_o, sof_err_o}, 0);
    @(posedge clk_i);
    #2 srst_i = 1'b0;
    @(posedge clk_i);
    #1;
    push_exp(0, NPIX);
    send_pixels(0, NPIX, 1'b1, 1'b0);
    wait_drain();

    // Two frames back to back, sof only on the first
    rdy_mode = 1;
    push_exp(0, NPIX);
    push_exp(0, NPIX);
    send_pixels(0, NPIX, 1'b1, 1'b0);
    send_pixels(0, NPIX, 1'b0, 1'b1);
    wait_drain();
    rdy_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
